instr_fetch: RTL and testbench

Instruction fetch sequencer that sits directly upstream of the instruction register. It holds the program counter and runs a read handshake with instruction memory. On completion it drives the fetched word onto the IR's 16-bit input bus with a one-cycle IR write strobe. It also supports jump loading of the PC, a halt gate, and a bounded wait with an error pulse when memory never answers.

---
 rtl/instr_fetch.sv | 96 +++++++++
 tb/tb_instr_fetch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer feeding the instruction register.
// Holds the program counter and runs a read handshake with instruction memory:
// while mem_rd is high the address is held stable, and the transfer completes
// in the first cycle mem_ready is sampled high (mem_data is valid only then).
// A completed read is presented on im with a one-cycle ir_wr strobe. If no
// ready arrives within TIMEOUT FETCH cycles, the read is abandoned and
// fetch_err pulses for one cycle.
module instr_fetch #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic              halt,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] im,
    output logic              ir_wr,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              fetch_err,
    output logic [1:0]        fsm_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;

    // Sequencer: state, PC, instruction latch, wait counter and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= ADDR_W'(RESET_PC);
            im        <= '0;
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            fetch_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    wait_cnt <= '0;
                    if (!halt) begin
                        // A jump in the same cycle as a request is fetched from the new PC.
                        if (jump_en) pc <= jump_addr;
                        if (fetch_req) state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Ready on the last permitted cycle still completes the read.
                    if (mem_ready) begin
                        im       <= mem_data;
                        wait_cnt <= '0;
                        state    <= S_LOAD;
                    end else if (wait_cnt == CNT_LAST) begin
                        fetch_err <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    // Advance on the same edge the IR captures im; wraps naturally.
                    pc    <= pc + ADDR_W'(1);
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes and buses decoded from state so reset clears them immediately.
    always_comb begin
        mem_addr  = pc;
        mem_rd    = (state == S_FETCH);
        ir_wr     = (state == S_LOAD);
        busy      = (state != S_IDLE);
        fsm_state = state;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed test-plan scenarios plus
// randomized transactions checked against a transaction-level model.
module tb_instr_fetch;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 8;
  localparam int RESET_PC = 0;
  localparam int TIMEOUT  = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fetch_req = 1'b0;
  logic              halt = 1'b0;
  logic              jump_en = 1'b0;
  logic [ADDR_W-1:0] jump_addr = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_data = '0;
  logic              mem_ready = 1'b0;
  logic [DATA_W-1:0] im;
  logic              ir_wr;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              fetch_err;
  logic [1:0]        fsm_state;

  int checks = 0;
  int failures = 0;
  int model_pc = RESET_PC;
  logic [DATA_W-1:0] exp_q[$];

  instr_fetch #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .halt(halt),
    .jump_en(jump_en), .jump_addr(jump_addr), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .im(im), .ir_wr(ir_wr), .pc(pc), .busy(busy), .fetch_err(fetch_err),
    .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every IR write must match the next expected instruction word
  always @(negedge clk) begin
    if (!rst && ir_wr === 1'b1) begin
      if (exp_q.size() == 0) check_val("ir_wr_unexpected", ir_wr, 0);
      else check_val("im_scoreboard", im, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One fetch transaction; w = wait cycles before ready (w >= TIMEOUT: never ready).
  // Called at posedge+1 with the DUT in IDLE.
  task automatic fetch_txn(input bit jmp, input logic [ADDR_W-1:0] ja,
                           input int w, input logic [DATA_W-1:0] d);
    logic [ADDR_W-1:0] ea;
    bit ok;
    int n;
    ea = jmp ? ja : ADDR_W'(model_pc);
    ok = (w < TIMEOUT);
    n  = ok ? w + 1 : TIMEOUT;
    halt = 1'b0; fetch_req = 1'b1; jump_en = jmp; jump_addr = ja; mem_ready = 1'b0;
    step();
    fetch_req = 1'b0;
    for (int k = 1; k <= n; k++) begin
      check_val("fetch_mem_rd", mem_rd, 1);
      check_val("fetch_mem_addr", mem_addr, ea);
      check_val("fetch_busy", busy, 1);
      // jump and halt must be ignored while fetching
      jump_en = 1'($urandom_range(0, 1));
      jump_addr = ADDR_W'($urandom);
      halt = 1'($urandom_range(0, 1));
      if (ok && k == n) begin
        mem_ready = 1'b1; mem_data = d; exp_q.push_back(d);
      end else begin
        mem_ready = 1'b0; mem_data = DATA_W'($urandom);
      end
      step();
    end
    mem_ready = 1'b0; jump_en = 1'b0; halt = 1'b0;
    if (ok) begin
      check_val("load_ir_wr", ir_wr, 1);
      check_val("load_mem_rd", mem_rd, 0);
      check_val("load_im", im, d);
      check_val("load_err", fetch_err, 0);
      check_val("load_pc_before", pc, ea);
      step();
      check_val("idle_ir_wr", ir_wr, 0);
      check_val("idle_busy", busy, 0);
      model_pc = (int'(ea) + 1) % (1 << ADDR_W);
      check_val("pc_incr", pc, model_pc);
      check_val("im_hold", im, d);
    end else begin
      check_val("timeout_err", fetch_err, 1);
      check_val("timeout_ir_wr", ir_wr, 0);
      check_val("timeout_busy", busy, 0);
      check_val("timeout_mem_rd", mem_rd, 0);
      model_pc = int'(ea);
      check_val("timeout_pc", pc, model_pc);
      step();
      check_val("err_one_cycle", fetch_err, 0);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    int w;

    // reset values
    #2;
    check_val("rst_pc", pc, RESET_PC);
    check_val("rst_im", im, 0);
    check_val("rst_ir_wr", ir_wr, 0);
    check_val("rst_mem_rd", mem_rd, 0);
    check_val("rst_err", fetch_err, 0);
    check_val("rst_busy", busy, 0);
    step();
    rst = 1'b0;
    step();

    // zero-wait, delayed-ready, timeout, jump with wrap
    fetch_txn(0, 8'h00, 0, 16'h1234);
    fetch_txn(0, 8'h00, 4, 16'hABCD);
    fetch_txn(0, 8'h00, TIMEOUT, 16'h0000);
    fetch_txn(1, 8'hFF, 0, 16'h0F0F);
    check_val("wrap_pc", pc, 0);

    // halt gates requests and jumps
    halt = 1'b1; fetch_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      jump_en = 1'($urandom_range(0, 1)); jump_addr = ADDR_W'($urandom);
      step();
      check_val("halt_mem_rd", mem_rd, 0);
      check_val("halt_busy", busy, 0);
      check_val("halt_pc", pc, model_pc);
    end
    jump_en = 1'b0;
    fetch_txn(0, 8'h00, 1, 16'h5A5A);

    // ready on the very last permitted cycle wins over timeout
    fetch_txn(0, 8'h00, TIMEOUT - 1, 16'hC3C3);

    // back-to-back fetches with fetch_req held and zero-wait memory
    d1 = DATA_W'($urandom); d2 = DATA_W'($urandom);
    fetch_req = 1'b1; mem_ready = 1'b1; mem_data = d1;
    exp_q.push_back(d1); exp_q.push_back(d2);
    step();
    check_val("b2b_addr0", mem_addr, model_pc);
    step();
    check_val("b2b_load0", ir_wr, 1);
    mem_data = d2;
    step();
    check_val("b2b_idle", busy, 0);
    check_val("b2b_pc1", pc, (model_pc + 1) % 256);
    step();
    fetch_req = 1'b0;
    check_val("b2b_addr1", mem_addr, (model_pc + 1) % 256);
    step();
    check_val("b2b_load1", ir_wr, 1);
    mem_ready = 1'b0;
    step();
    model_pc = (model_pc + 2) % 256;
    check_val("b2b_pc2", pc, model_pc);

    // asynchronous reset in the middle of FETCH drops the transaction
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check_val("pre_rst_mem_rd", mem_rd, 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_mem_rd", mem_rd, 0);
    check_val("arst_ir_wr", ir_wr, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_pc", pc, RESET_PC);
    check_val("arst_im", im, 0);
    step();
    rst = 1'b0;
    model_pc = RESET_PC;
    step();
    check_val("post_rst_pc", pc, RESET_PC);

    // randomized transactions
    for (int i = 0; i < 40; i++) begin
      w = ($urandom_range(0, 7) == 0) ? TIMEOUT + int'($urandom_range(0, 2))
                                      : int'($urandom_range(0, 5));
      fetch_txn(1'($urandom_range(0, 3) == 0), ADDR_W'($urandom), w, DATA_W'($urandom));
      if ($urandom_range(0, 1) == 1) step();
    end

    step();
    step();
    check_val("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
